// File: rtl/sme_pkg.sv
// sme_pkg: shared types and defaults for the SME mask generator control.
// Holds the RNG sequencer state enum, default round counts and a width helper.
package sme_pkg;

  typedef enum logic [0:0] {
    SEED = 1'b0,
    RUN  = 1'b1
  } sme_rng_state_t;

  localparam int SME_RNG_SEED_ROUNDS = 24;
  localparam int SME_RNG_MIN_ROUNDS  = 2;

  function automatic int sme_clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sme_rng_ctrl_if.sv
// sme_rng_ctrl_if: TRNG handshake plus mask requester bus.
// master = TRNG/requester side, slave = sme_rng_ctrl.
interface sme_rng_ctrl_if #(
  parameter int TAPS = 1,
  parameter int NREQ = 4,
  parameter int MW   = 32
);

  logic            trng_valid;
  logic [TAPS-1:0] trng_data;
  logic            trng_ready;
  logic            reseed;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [MW-1:0]   rsp_mask;

  modport master (
    output trng_valid, trng_data, reseed, req,
    input  trng_ready, gnt, rsp_mask
  );

  modport slave (
    input  trng_valid, trng_data, reseed, req,
    output trng_ready, gnt, rsp_mask
  );

endinterface

// File: rtl/sme_rr_arb.sv
// sme_rr_arb: combinational round-robin picker.
// req: requests, ptr: highest-priority index; gnt: one-hot winner, idx: its index.
module sme_rr_arb #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/sme_rng_ctrl.sv
// sme_rng_ctrl: seeds/reseeds the Keccak mask generator from the TRNG and
// hands out masks round-robin, at least MIN_ROUNDS updates apart.
// Ports: g_clk, g_resetn (async, active-low); bus (TRNG handshake, reseed,
// req/gnt/rsp_mask); kc_update/kc_taps to generator; kc_state from it;
// seeded; entropy_low.
// Option: SME_RNG_CTRL_HEALTH_EN builds the entropy starvation counter.
module sme_rng_ctrl
  import sme_pkg::*;
#(
  parameter int LW          = 8,
  parameter int TAPS        = 1,
  parameter int NREQ        = 4,
  parameter int MW          = 32,
  parameter int SEED_ROUNDS = SME_RNG_SEED_ROUNDS,
  parameter int MIN_ROUNDS  = SME_RNG_MIN_ROUNDS,
  parameter int MAX_NOENT   = 64
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  sme_rng_ctrl_if.slave     bus,
  output logic              kc_update,
  output logic [TAPS-1:0]   kc_taps,
  input  logic [LW*25-1:0]  kc_state,
  output logic              seeded,
  output logic              entropy_low
);

  localparam int SW = sme_clog2w(SEED_ROUNDS + 1);
  localparam int FW = sme_clog2w(MIN_ROUNDS + 1);
  localparam int PW = sme_clog2w(NREQ);

  localparam logic [0:0] ST_SEED = SEED;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]      r_state;
  logic [SW-1:0]   r_seed_cnt;
  logic [FW-1:0]   r_fresh;
  logic [PW-1:0]   r_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [MW-1:0]   r_mask;

  logic            w_run;
  logic            w_fresh_ok;
  logic            w_seed_last;
  logic            w_arb;
  logic [NREQ-1:0] w_win;
  logic [PW-1:0]   w_idx;
  logic [PW-1:0]   w_ptr_nxt;

  assign w_run       = (r_state == ST_RUN);
  assign w_fresh_ok  = (r_fresh == FW'(MIN_ROUNDS));
  assign w_seed_last = (r_seed_cnt == SW'(SEED_ROUNDS - 1));

  // SEED updates only on a TRNG word; RUN permutes every cycle.
  assign kc_update = w_run | bus.trng_valid;
  assign kc_taps   = (w_run && !bus.trng_valid) ? '0 : bus.trng_data;
  assign bus.trng_ready = bus.trng_valid;

  assign w_arb = w_run & w_fresh_ok & (|bus.req) & ~bus.reseed;

  sme_rr_arb #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .req (bus.req),
    .ptr (r_ptr),
    .gnt (w_win),
    .idx (w_idx)
  );

  assign w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state    <= ST_SEED;
      r_seed_cnt <= '0;
      r_fresh    <= '0;
      r_ptr      <= '0;
    end else if (bus.reseed) begin
      r_state    <= ST_SEED;
      r_seed_cnt <= '0;
      r_fresh    <= '0;
    end else if (!w_run) begin
      if (bus.trng_valid) begin
        r_seed_cnt <= r_seed_cnt + 1'b1;
        if (w_seed_last) begin
          r_state <= ST_RUN;
          r_fresh <= FW'(MIN_ROUNDS);
        end
      end
    end else if (w_arb) begin
      r_fresh <= '0;
      r_ptr   <= w_ptr_nxt;
    end else if (!w_fresh_ok) begin
      r_fresh <= r_fresh + 1'b1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_gnt  <= '0;
      r_mask <= '0;
    end else begin
      r_gnt <= w_arb ? w_win : '0;
      if (w_arb) r_mask <= kc_state[MW-1:0];
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.rsp_mask = r_mask;
  assign seeded       = w_run;

  // Only the low MW state bits feed masks.
  logic w_unused_st;
  generate
    if (MW < LW * 25) begin : g_unused_st
      assign w_unused_st = ^kc_state[LW*25-1:MW];
    end else begin : g_no_unused_st
      assign w_unused_st = 1'b0;
    end
  endgenerate

`ifdef SME_RNG_CTRL_HEALTH_EN
  localparam int NW = sme_clog2w(MAX_NOENT + 1);

  logic [NW-1:0] r_noent;
  logic [NW-1:0] w_noent_nxt;
  logic          r_elow;

  // An update without a valid word can only happen in RUN.
  always_comb begin
    w_noent_nxt = r_noent;
    if (kc_update) begin
      if (bus.trng_valid)
        w_noent_nxt = '0;
      else if (r_noent != NW'(MAX_NOENT))
        w_noent_nxt = r_noent + 1'b1;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_noent <= '0;
      r_elow  <= 1'b0;
    end else begin
      r_noent <= w_noent_nxt;
      r_elow  <= (w_noent_nxt >= NW'(MAX_NOENT));
    end
  end

  assign entropy_low = r_elow;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (MAX_NOENT == 0);
  assign entropy_low  = 1'b0;
`endif

endmodule

// File: tb/tb_sme_rng_ctrl.sv
// tb_sme_rng_ctrl: directed + random checks of sme_rng_ctrl
// against a cycle-level behavioural model.
module tb_sme_rng_ctrl;
  import sme_pkg::*;

  localparam int LW   = 8;
  localparam int TAPS = 1;
  localparam int NREQ = 4;
  localparam int MW   = 32;
  localparam int SR   = 24;
  localparam int MR   = 2;
  localparam int MN   = 64;
`ifdef SME_RNG_CTRL_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif

  logic              g_clk = 1'b0;
  logic              g_resetn = 1'b0;
  logic              kc_update;
  logic [TAPS-1:0]   kc_taps;
  logic [LW*25-1:0]  kc_state;
  logic              seeded;
  logic              entropy_low;

  sme_rng_ctrl_if #(.TAPS(TAPS), .NREQ(NREQ), .MW(MW)) bus ();

  sme_rng_ctrl #(
    .LW(LW), .TAPS(TAPS), .NREQ(NREQ), .MW(MW),
    .SEED_ROUNDS(SR), .MIN_ROUNDS(MR), .MAX_NOENT(MN)
  ) dut (
    .g_clk       (g_clk),
    .g_resetn    (g_resetn),
    .bus         (bus),
    .kc_update   (kc_update),
    .kc_taps     (kc_taps),
    .kc_state    (kc_state),
    .seeded      (seeded),
    .entropy_low (entropy_low)
  );

  always #5 g_clk = ~g_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model
  bit              m_seeded;
  int              m_seed, m_fresh, m_ptr, m_noent;
  logic [NREQ-1:0] m_gnt;
  logic [MW-1:0]   m_mask;
  bit              m_elow;

  task automatic m_reset();
    m_seeded = 0; m_seed = 0; m_fresh = 0; m_ptr = 0;
    m_noent = 0; m_gnt = '0; m_mask = '0; m_elow = 0;
  endtask

  task automatic step();
    bit upd, grant;
    int w;
    for (int i = 0; i < 25; i++) kc_state[i*8 +: 8] = 8'($urandom);
    bus.trng_data = TAPS'($urandom);
    #1;
    upd = m_seeded || bus.trng_valid;
    chk("kc_update", 64'(kc_update), 64'(upd));
    chk("kc_taps", 64'(kc_taps),
        (m_seeded && !bus.trng_valid) ? 64'(0) : 64'(bus.trng_data));
    chk("trng_ready", 64'(bus.trng_ready), 64'(bus.trng_valid));
    grant = m_seeded && (m_fresh == MR) && (bus.req != 0) && !bus.reseed;
    w = 0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    if (upd) begin
      if (bus.trng_valid) m_noent = 0;
      else if (m_noent < MN) m_noent++;
    end
    m_elow = HEALTH && (m_noent >= MN);
    m_gnt = grant ? NREQ'(1 << w) : '0;
    if (grant) m_mask = kc_state[MW-1:0];
    if (bus.reseed) begin
      m_seeded = 0; m_seed = 0; m_fresh = 0;
    end else if (!m_seeded) begin
      if (bus.trng_valid) begin
        m_seed++;
        if (m_seed == SR) begin m_seeded = 1; m_fresh = MR; end
      end
    end else if (grant) begin
      m_fresh = 0;
      m_ptr = (w + 1) % NREQ;
    end else if (m_fresh < MR) begin
      m_fresh++;
    end
    @(posedge g_clk);
    #1;
    chk("gnt", 64'(bus.gnt), 64'(m_gnt));
    chk("rsp_mask", 64'(bus.rsp_mask), 64'(m_mask));
    chk("seeded", 64'(seeded), 64'(m_seeded));
    chk("entropy_low", 64'(entropy_low), 64'(m_elow));
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    bus.trng_valid = 1'b0; bus.trng_data = '0;
    bus.reseed = 1'b0; bus.req = '0;
    kc_state = '0;
    repeat (2) @(posedge g_clk);
    #1;
    chk("rst_gnt", 64'(bus.gnt), 64'(0));
    chk("rst_mask", 64'(bus.rsp_mask), 64'(0));
    chk("rst_seeded", 64'(seeded), 64'(0));
    chk("rst_elow", 64'(entropy_low), 64'(0));
    chk("rst_upd", 64'(kc_update), 64'(0));
    chk("rst_ready", 64'(bus.trng_ready), 64'(0));
    @(negedge g_clk);
    g_resetn = 1'b1;
    m_reset();
  endtask

  // requesters hold req until granted, then may re-request
  task automatic drive_rand(input int pv, input bit rs_en);
    bus.trng_valid = ($urandom_range(99) < pv);
    for (int i = 0; i < NREQ; i++)
      if (!(bus.req[i] && !m_gnt[i]))
        bus.req[i] = ($urandom_range(2) == 0);
    bus.reseed = rs_en && ($urandom_range(99) == 0);
  endtask

  task automatic drop_granted();
    for (int i = 0; i < NREQ; i++)
      if (m_gnt[i]) bus.req[i] = 1'b0;
  endtask

  initial begin
    int n, g, last, t;
    bit done;

    do_reset();

    // seeding, steady TRNG
    bus.trng_valid = 1'b1;
    bus.req = NREQ'(1);
    n = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      step(); n++;
      if (seeded) done = 1;
    end
    chk("seed_lat", 64'(n), 64'(SR));
    step();
    chk("seed_gnt", 64'(bus.gnt), 64'(1));
    chk("seed_mask", 64'(bus.rsp_mask), 64'(kc_state[MW-1:0]));

    // seeding, gappy TRNG
    do_reset();
    n = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      bus.trng_valid = (c % 2 == 1);
      step(); n++;
      if (seeded) done = 1;
    end
    chk("gap_lat", 64'(n), 64'(2 * SR));

    // round robin and spacing
    do_reset();
    bus.trng_valid = 1'b1;
    bus.req = '1;
    g = 0; last = 0; t = 0;
    for (int c = 0; c < 300 && g < 5; c++) begin
      step(); t++;
      if (bus.gnt != 0) begin
        chk($sformatf("rr_gnt%0d", g), 64'(bus.gnt), 64'(1 << (g % NREQ)));
        if (g > 0) chk("rr_gap", 64'(t - last), 64'(MR + 1));
        last = t;
        g++;
      end
    end
    chk("rr_count", 64'(g), 64'(5));

    // reseed in the arbitration cycle
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (m_seeded && m_fresh == MR && bus.req != 0) done = 1;
      else step();
    end
    chk("rs_found", 64'(done), 64'(1));
    bus.reseed = 1'b1;
    step();
    bus.reseed = 1'b0;
    chk("rs_nognt", 64'(bus.gnt), 64'(0));
    chk("rs_seeded", 64'(seeded), 64'(0));
    n = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      step(); n++;
      if (bus.gnt != 0) done = 1;
    end
    chk("rs_lat", 64'(n), 64'(SR + 1));

    // random traffic with reseeds
    for (int c = 0; c < 3000; c++) begin
      drive_rand(70, 1'b1);
      step();
    end

    // entropy starvation
    bus.reseed = 1'b0;
    bus.trng_valid = 1'b1;
    for (int c = 0; c < 200 && !m_seeded; c++) begin
      drop_granted();
      step();
    end
    chk("h_seeded", 64'(seeded), 64'(1));
    bus.trng_valid = 1'b0;
    for (int c = 0; c < MN; c++) begin
      drop_granted();
      step();
      if (c == MN - 2) chk("elow_early", 64'(entropy_low), 64'(0));
    end
    chk("elow_set", 64'(entropy_low), 64'(HEALTH));
    bus.trng_valid = 1'b1;
    drop_granted();
    step();
    chk("elow_clr", 64'(entropy_low), 64'(0));

    // async reset in a grant cycle
    bus.req = '1;
    done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      step();
      if (bus.gnt != 0) done = 1;
    end
    chk("ar_hit", 64'(done), 64'(1));
    #2;
    g_resetn = 1'b0;
    #1;
    chk("ar_gnt", 64'(bus.gnt), 64'(0));
    chk("ar_mask", 64'(bus.rsp_mask), 64'(0));
    chk("ar_seeded", 64'(seeded), 64'(0));
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sme_rng_ctrl.md
# sme_rng_ctrl

Sequencer and arbiter for the SME Keccak-based mask generator. Drives the generator's `update` and `taps` inputs, consumes TRNG words to seed and reseed it, and shares its state among `NREQ` mask requesters with round-robin arbitration. It guarantees that at least `MIN_ROUNDS` permutation rounds separate any two masks handed out. The block sits between the TRNG front-end, the Keccak state register and the masked functional units.

## Interface

**Parameters**
- `LW`, default 8: Keccak lane width; must match the generator instance.
- `TAPS`, default 1: TRNG bits per update; must match the generator instance.
- `NREQ`, default 4: number of mask requesters, 1..8.
- `MW`, default 32: mask width; `MW` ≤ `LW*25`.
- `SEED_ROUNDS`, default 24: entropy-carrying updates required before the first grant.
- `MIN_ROUNDS`, default 2: minimum updates between consecutive grants; ≥ 1.
- `MAX_NOENT`, default 64: consecutive entropy-free updates before `entropy_low` is raised.

**Ports**
- `g_clk` in 1: clock.
- `g_resetn` in 1: reset, asynchronous, active-low.
- `trng_valid` in 1: TRNG word available.
- `trng_data` in `TAPS`: TRNG word.
- `trng_ready` out 1: word consumed this cycle.
- `reseed` in 1: single-cycle pulse that forces a fresh seeding phase.
- `kc_update` out 1: connects to the generator's `update`.
- `kc_taps` out `TAPS`: connects to the generator's `taps`.
- `kc_state` in `LW*25`: generator state.
- `req` in `NREQ`: per-requester mask request (level).
- `gnt` out `NREQ`: one-hot grant pulse.
- `rsp_mask` out `MW`: mask; valid in the cycle `gnt` is high.
- `seeded` out 1: high in RUN.
- `entropy_low` out 1: entropy starvation flag (only when `SME_RNG_CTRL_HEALTH_EN` is defined).

## Operation

- **FSM states.** Two states: SEED and RUN. Reset value is SEED.
- **SEED.**
  - `kc_update` = `trng_ready` = `trng_valid`.
  - `kc_taps` = `trng_data`.
  - `seed_cnt` counts updates. When an update brings it to `SEED_ROUNDS`, the FSM moves to RUN and `fresh_cnt` is set to `MIN_ROUNDS`.
  - No grants are issued.
- **RUN.**
  - `kc_update` = 1 every cycle.
  - `kc_taps` = `trng_valid ? trng_data : 0`.
  - `trng_ready` = `trng_valid`.
- **fresh_cnt.** Saturates at `MIN_ROUNDS`. Increments on each update and is cleared on a grant.
- **Arbitration (cycle t).** When in RUN, `fresh_cnt == MIN_ROUNDS`, `req != 0` and `reseed` is low:
  - Pick the first set `req` bit at or after `rr_ptr`, wrapping modulo `NREQ`.
  - At the t→t+1 edge: `gnt` ← one-hot winner, `rsp_mask` ← `kc_state[MW-1:0]` sampled at t, `fresh_cnt` ← 0, `rr_ptr` ← winner+1 mod `NREQ`.
- **Outputs outside a grant cycle.** `gnt` = 0. `rsp_mask` holds its last value.
- **reseed pulse.**
  - Next state is SEED; `seed_cnt` ← 0; `fresh_cnt` ← 0.
  - Any arbitration in that same cycle is cancelled.
  - A `gnt` already registered for the current cycle still completes.
- **Requester rules.**
  - A requester holds `req` until it sees `gnt`.
  - `req` still high in the `gnt` cycle is a new request.
  - Dropping `req` early is a protocol violation and the behaviour is unspecified.
- **Reset values.** State = SEED; all counters 0; `rr_ptr` = 0; `gnt` = 0; `rsp_mask` = 0; `seeded` = 0; `entropy_low` = 0. Combinational outputs (`kc_update`, `trng_ready`) follow their equations, which evaluate to 0 while `trng_valid` is 0.

## Timing

- **Request to grant.** With `req` high and `fresh_cnt` saturated, `gnt` rises the next cycle.
- **Maximum grant rate.** One grant per `MIN_ROUNDS+1` cycles. A grant at t+1 allows the next arbitration at t+1+`MIN_ROUNDS`.
- **Post-reset latency.** The first grant is possible no earlier than cycle `SEED_ROUNDS+1` after reset release, with `trng_valid` held high throughout.
- **Reset during operation.** Asynchronous reset mid-operation returns the block to the SEED state with the reset values listed above. The generator's own reset is separate and is not driven here.

## Configuration

- **`SME_RNG_CTRL_HEALTH_EN` defined:**
  - `noent_cnt` (saturating) increments on each RUN update made with `trng_valid` = 0.
  - It clears on each update made with `trng_valid` = 1, and on reset.
  - `entropy_low` is registered high while `noent_cnt` ≥ `MAX_NOENT`.
- **`SME_RNG_CTRL_HEALTH_EN` not defined:** `entropy_low` is tied to 0 and the counter is not built.

## Structure

- **Shared package `sme_pkg`:**
  - FSM state enum `sme_rng_state_t` {SEED, RUN}.
  - Default constants `SME_RNG_SEED_ROUNDS` and `SME_RNG_MIN_ROUNDS`.
- **Sub-module:** `sme_rr_arb`, a parameterised round-robin one-hot picker with inputs `req` and `ptr`.
- **Generator instance:** instantiated by the parent, not inside this block.

## Test plan

1. **Seeding:** reset, `trng_valid` = 1 constantly, `req[0]` high → `seeded` rises after 24 updates; `gnt` = 4'b0001 one cycle later; `rsp_mask` = `kc_state[31:0]` from the preceding cycle.
2. **Seeding with a gappy TRNG:** `trng_valid` toggles 1/0 → seeding takes 48 cycles; `kc_update` is never high while `trng_valid` = 0 in SEED.
3. **Round robin and spacing:** all four `req` held high → grant order 0,1,2,3,0, with exactly 3 cycles between `gnt` pulses.
4. **reseed collision:** `reseed` in the arbitration cycle → no grant follows; `seeded` drops; the next grant comes only after 24 further entropy updates.
5. **Health flag (macro on):** in RUN, `trng_valid` = 0 for 64 cycles → `entropy_low` = 1; one valid word → `entropy_low` = 0 the next cycle. With the macro off, `entropy_low` stays 0.
6. **Asynchronous reset:** `g_resetn` low mid-grant → `gnt`, `rsp_mask` and `seeded` clear immediately, without waiting for a clock edge.
